// File: rtl/stopwatch_pkg.sv
// Shared types and helpers for the stopwatch timekeeping core.
// Holds the control-state encoding and the mm:ss arithmetic used by the live counter.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUNNING = 2'd1,
    PAUSED  = 2'd2
  } sw_state_t;

  localparam logic [5:0] SEC_MAX = 6'd59;
  localparam logic [5:0] MIN_MAX = 6'd59;

  typedef struct packed {
    logic [5:0] minutes;
    logic [5:0] seconds;
  } mmss_t;

  // One-second advance with wrap from 59:59 back to 00:00
  function automatic mmss_t mmss_inc(input mmss_t t);
    mmss_t n;
    n = t;
    if (t.seconds < SEC_MAX) begin
      n.seconds = t.seconds + 6'd1;
    end else begin
      n.seconds = 6'd0;
      n.minutes = (t.minutes < MIN_MAX) ? t.minutes + 6'd1 : 6'd0;
    end
    return n;
  endfunction

  function automatic logic mmss_is_max(input mmss_t t);
    return (t.minutes == MIN_MAX) && (t.seconds == SEC_MAX);
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Divides the system clock down to one tick per TICK_DIV enabled cycles.
// The partial count is kept while disabled so a resumed run keeps its fraction of a second.
module tick_prescaler #(
  parameter int TICK_DIV = 100_000_000
) (
  input  logic clock,
  input  logic reset,
  input  logic enable,
  input  logic clear,
  output logic tick
);

  localparam int PRESC_W = $clog2(TICK_DIV);
  localparam logic [PRESC_W-1:0] LAST = PRESC_W'(TICK_DIV - 1);

  logic [PRESC_W-1:0] count;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= (count == LAST) ? '0 : count + 1'b1;
    end
  end

  assign tick = enable && (count == LAST);

endmodule

// File: rtl/stopwatch_controller.sv
// Stopwatch control core: run/pause/clear sequencing, mm:ss live count and lap freeze.
// Display outputs are a zero-latency mux between the live and the captured lap registers.
module stopwatch_controller
  import stopwatch_pkg::*;
#(
  parameter int TICK_DIV = 100_000_000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start_stop_pulse,
  input  logic       clear_pulse,
  input  logic       lap_pulse,
  output logic [5:0] minutes,
  output logic [5:0] seconds,
  output logic       running,
  output logic       lap_held,
  output logic       overflow,
  output logic       second_tick
);

  sw_state_t state;
  mmss_t     live_time;
  mmss_t     lap_time;
  logic      lap_held_r;
  logic      overflow_r;
  logic      tick;
  logic      count_enable;

  assign count_enable = (state == RUNNING);

  tick_prescaler #(
    .TICK_DIV(TICK_DIV)
  ) u_prescaler (
    .clock  (clock),
    .reset  (reset),
    .enable (count_enable),
    .clear  (clear_pulse),
    .tick   (tick)
  );

  // Clear beats everything; start_stop beats lap, but a tick still lands in its cycle
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      live_time  <= '0;
      lap_time   <= '0;
      lap_held_r <= 1'b0;
      overflow_r <= 1'b0;
    end else if (clear_pulse) begin
      state      <= IDLE;
      live_time  <= '0;
      lap_time   <= '0;
      lap_held_r <= 1'b0;
      overflow_r <= 1'b0;
    end else begin
      if (tick) begin
        live_time <= mmss_inc(live_time);
        if (mmss_is_max(live_time)) begin
          overflow_r <= 1'b1;
        end
      end
      case (state)
        IDLE: begin
          if (start_stop_pulse) begin
            state <= RUNNING;
          end
        end
        RUNNING: begin
          if (start_stop_pulse) begin
            state <= PAUSED;
          end else if (lap_pulse) begin
            if (lap_held_r) begin
              lap_held_r <= 1'b0;
            end else begin
              lap_time   <= live_time;
              lap_held_r <= 1'b1;
            end
          end
        end
        PAUSED: begin
          if (start_stop_pulse) begin
            state <= RUNNING;
          end else if (lap_pulse && lap_held_r) begin
            lap_held_r <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign minutes     = lap_held_r ? lap_time.minutes : live_time.minutes;
  assign seconds     = lap_held_r ? lap_time.seconds : live_time.seconds;
  assign running     = (state == RUNNING);
  assign lap_held    = lap_held_r;
  assign overflow    = overflow_r;
  assign second_tick = tick;

endmodule

// File: tb/tb_stopwatch_controller.sv
// Self-checking bench for stopwatch_controller with TICK_DIV=4.
// Reference model tracks total running cycles since clear and derives mm:ss from it arithmetically.
module tb_stopwatch_controller;

  localparam int TD = 4;

  logic       clock;
  logic       reset;
  logic       start_stop_pulse;
  logic       clear_pulse;
  logic       lap_pulse;
  logic [5:0] minutes;
  logic [5:0] seconds;
  logic       running;
  logic       lap_held;
  logic       overflow;
  logic       second_tick;

  int checks;
  int errors;

  int m_elapsed;
  bit m_run;
  bit m_pause;
  bit m_lap_held;
  int m_lap_val;

  stopwatch_controller #(
    .TICK_DIV(TD)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .start_stop_pulse (start_stop_pulse),
    .clear_pulse      (clear_pulse),
    .lap_pulse        (lap_pulse),
    .minutes          (minutes),
    .seconds          (seconds),
    .running          (running),
    .lap_held         (lap_held),
    .overflow         (overflow),
    .second_tick      (second_tick)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic int exp_total();
    return m_lap_held ? m_lap_val : (m_elapsed / TD) % 3600;
  endfunction

  function automatic int exp_overflow();
    return ((m_elapsed / TD) >= 3600) ? 1 : 0;
  endfunction

  function automatic int exp_tick();
    return (m_run && (m_elapsed % TD == TD - 1)) ? 1 : 0;
  endfunction

  task automatic model_reset();
    m_elapsed  = 0;
    m_run      = 1'b0;
    m_pause    = 1'b0;
    m_lap_held = 1'b0;
    m_lap_val  = 0;
  endtask

  // Drive one cycle of pulses and advance the reference model at the same edge
  task automatic drive_cycle(input bit ss, input bit clr, input bit lp);
    @(negedge clock);
    start_stop_pulse = ss;
    clear_pulse      = clr;
    lap_pulse        = lp;
    @(posedge clock);
    if (clr) begin
      model_reset();
    end else begin
      if (lp && !ss) begin
        if (m_lap_held) begin
          if (m_run || m_pause) m_lap_held = 1'b0;
        end else if (m_run) begin
          m_lap_val  = (m_elapsed / TD) % 3600;
          m_lap_held = 1'b1;
        end
      end
      if (m_run) m_elapsed++;
      if (ss) begin
        if (m_run) begin
          m_run = 1'b0; m_pause = 1'b1;
        end else begin
          m_run = 1'b1; m_pause = 1'b0;
        end
      end
    end
    #1;
    start_stop_pulse = 1'b0;
    clear_pulse      = 1'b0;
    lap_pulse        = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start_stop_pulse = 1'b0;
    clear_pulse = 1'b0;
    lap_pulse = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    checks++;
    if ({minutes, seconds, running, lap_held, overflow, second_tick} !== 16'h0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got %h expected 0", {minutes, seconds, running, lap_held, overflow, second_tick});
    end
    @(negedge clock);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_run();
    int ticks;
    ticks = 0;
    drive_cycle(1, 0, 0);
    checks++;
    if (running !== 1'b1) begin
      errors++; $display("[TB] FAIL run_start: running got %0d expected 1", running);
    end
    for (int i = 1; i <= 240; i++) begin
      drive_cycle(0, 0, 0);
      if (second_tick) ticks++;
      checks++;
      if (second_tick !== exp_tick()) begin
        errors++; $display("[TB] FAIL run_tick_c%0d: got %0d expected %0d", i, second_tick, exp_tick());
      end
      if (i == 3) begin
        checks++;
        if (seconds !== 6'd0) begin
          errors++; $display("[TB] FAIL run_sec_before_first: got %0d expected 0", seconds);
        end
      end
      if (i == 4) begin
        checks++;
        if (seconds !== 6'd1) begin
          errors++; $display("[TB] FAIL run_first_second: got %0d expected 1", seconds);
        end
      end
    end
    checks++;
    if (minutes !== 6'd1 || seconds !== 6'd0) begin
      errors++; $display("[TB] FAIL run_one_minute: got %0d:%0d expected 1:0", minutes, seconds);
    end
    checks++;
    if (ticks !== 60) begin
      errors++; $display("[TB] FAIL run_tick_count: got %0d expected 60", ticks);
    end
  endtask

  task automatic test_pause();
    drive_cycle(0, 1, 0);
    checks++;
    if (running !== 1'b0 || minutes !== 6'd0 || seconds !== 6'd0) begin
      errors++; $display("[TB] FAIL pause_clear: got run=%0d %0d:%0d expected 0 0:0", running, minutes, seconds);
    end
    drive_cycle(1, 0, 0);
    repeat (9) drive_cycle(0, 0, 0);
    drive_cycle(1, 0, 0);
    checks++;
    if (running !== 1'b0 || seconds !== 6'd2) begin
      errors++; $display("[TB] FAIL pause_enter: got run=%0d sec=%0d expected 0 2", running, seconds);
    end
    repeat (100) drive_cycle(0, 0, 0);
    checks++;
    if (running !== 1'b0 || minutes !== 6'd0 || seconds !== 6'd2) begin
      errors++; $display("[TB] FAIL pause_hold: got run=%0d %0d:%0d expected 0 0:2", running, minutes, seconds);
    end
    drive_cycle(1, 0, 0);
    drive_cycle(0, 0, 0);
    checks++;
    if (running !== 1'b1 || seconds !== 6'd2) begin
      errors++; $display("[TB] FAIL pause_resume_partial: got run=%0d sec=%0d expected 1 2", running, seconds);
    end
    drive_cycle(0, 0, 0);
    checks++;
    if (seconds !== 6'd3) begin
      errors++; $display("[TB] FAIL pause_resume_tick: got %0d expected 3", seconds);
    end
  endtask

  task automatic test_overflow();
    drive_cycle(0, 1, 0);
    drive_cycle(1, 0, 0);
    repeat (3599 * TD) drive_cycle(0, 0, 0);
    checks++;
    if (minutes !== 6'd59 || seconds !== 6'd59 || overflow !== 1'b0) begin
      errors++; $display("[TB] FAIL ovf_max: got %0d:%0d ovf=%0d expected 59:59 0", minutes, seconds, overflow);
    end
    repeat (TD) drive_cycle(0, 0, 0);
    checks++;
    if (minutes !== 6'd0 || seconds !== 6'd0 || overflow !== 1'b1 || running !== 1'b1) begin
      errors++; $display("[TB] FAIL ovf_wrap: got %0d:%0d ovf=%0d run=%0d expected 0:0 1 1", minutes, seconds, overflow, running);
    end
    repeat (TD) drive_cycle(0, 0, 0);
    checks++;
    if (seconds !== 6'd1 || overflow !== 1'b1) begin
      errors++; $display("[TB] FAIL ovf_continue: got sec=%0d ovf=%0d expected 1 1", seconds, overflow);
    end
    drive_cycle(0, 1, 0);
    checks++;
    if (overflow !== 1'b0 || running !== 1'b0 || seconds !== 6'd0) begin
      errors++; $display("[TB] FAIL ovf_clear: got ovf=%0d run=%0d sec=%0d expected 0 0 0", overflow, running, seconds);
    end
  endtask

  task automatic test_lap();
    drive_cycle(0, 1, 0);
    drive_cycle(1, 0, 0);
    repeat (5 * TD) drive_cycle(0, 0, 0);
    drive_cycle(0, 0, 1);
    checks++;
    if (lap_held !== 1'b1 || seconds !== 6'd5) begin
      errors++; $display("[TB] FAIL lap_capture: got held=%0d sec=%0d expected 1 5", lap_held, seconds);
    end
    for (int i = 0; i < 12; i++) begin
      drive_cycle(0, 0, 0);
      checks++;
      if (lap_held !== 1'b1 || minutes !== 6'd0 || seconds !== 6'd5) begin
        errors++; $display("[TB] FAIL lap_frozen_c%0d: got held=%0d %0d:%0d expected 1 0:5", i, lap_held, minutes, seconds);
      end
    end
    drive_cycle(0, 0, 1);
    checks++;
    if (lap_held !== 1'b0 || seconds !== 6'd8) begin
      errors++; $display("[TB] FAIL lap_release: got held=%0d sec=%0d expected 0 8", lap_held, seconds);
    end
    drive_cycle(0, 1, 0);
    drive_cycle(1, 0, 0);
    repeat (6 * TD - 1) drive_cycle(0, 0, 0);
    checks++;
    if (second_tick !== 1'b1 || seconds !== 6'd5) begin
      errors++; $display("[TB] FAIL lap_tick_setup: got tick=%0d sec=%0d expected 1 5", second_tick, seconds);
    end
    drive_cycle(0, 0, 1);
    checks++;
    if (lap_held !== 1'b1 || seconds !== 6'd5) begin
      errors++; $display("[TB] FAIL lap_tick_capture: got held=%0d sec=%0d expected 1 5", lap_held, seconds);
    end
    drive_cycle(0, 0, 1);
    checks++;
    if (lap_held !== 1'b0 || seconds !== 6'd6) begin
      errors++; $display("[TB] FAIL lap_tick_live: got held=%0d sec=%0d expected 0 6", lap_held, seconds);
    end
  endtask

  task automatic test_simultaneous();
    drive_cycle(0, 1, 0);
    drive_cycle(1, 0, 0);
    repeat (6) drive_cycle(0, 0, 0);
    drive_cycle(1, 1, 0);
    checks++;
    if (running !== 1'b0 || minutes !== 6'd0 || seconds !== 6'd0) begin
      errors++; $display("[TB] FAIL sim_clear_wins: got run=%0d %0d:%0d expected 0 0:0", running, minutes, seconds);
    end
    drive_cycle(1, 0, 0);
    repeat (4 * TD - 1) drive_cycle(0, 0, 0);
    checks++;
    if (second_tick !== 1'b1 || seconds !== 6'd3) begin
      errors++; $display("[TB] FAIL sim_tick_setup: got tick=%0d sec=%0d expected 1 3", second_tick, seconds);
    end
    drive_cycle(1, 0, 0);
    checks++;
    if (running !== 1'b0 || seconds !== 6'd4) begin
      errors++; $display("[TB] FAIL sim_pause_on_tick: got run=%0d sec=%0d expected 0 4", running, seconds);
    end
    drive_cycle(0, 0, 1);
    repeat (3) drive_cycle(0, 0, 0);
    checks++;
    if (lap_held !== 1'b0 || seconds !== 6'd4 || running !== 1'b0) begin
      errors++; $display("[TB] FAIL sim_lap_paused: got held=%0d sec=%0d run=%0d expected 0 4 0", lap_held, seconds, running);
    end
  endtask

  task automatic test_async_reset();
    drive_cycle(0, 1, 0);
    drive_cycle(1, 0, 0);
    repeat ((12 * 60 + 34) * TD) drive_cycle(0, 0, 0);
    drive_cycle(0, 0, 1);
    checks++;
    if (lap_held !== 1'b1 || minutes !== 6'd12 || seconds !== 6'd34) begin
      errors++; $display("[TB] FAIL arst_setup: got held=%0d %0d:%0d expected 1 12:34", lap_held, minutes, seconds);
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if ({minutes, seconds, running, lap_held, overflow} !== 15'h0) begin
      errors++; $display("[TB] FAIL arst_immediate: got %h expected 0", {minutes, seconds, running, lap_held, overflow});
    end
    @(negedge clock);
    reset = 1'b0;
    model_reset();
    drive_cycle(0, 0, 0);
    checks++;
    if (running !== 1'b0 || minutes !== 6'd0 || seconds !== 6'd0) begin
      errors++; $display("[TB] FAIL arst_idle: got run=%0d %0d:%0d expected 0 0:0", running, minutes, seconds);
    end
  endtask

  task automatic test_random();
    bit ss, clr, lp;
    drive_cycle(0, 1, 0);
    drive_cycle(1, 0, 0);
    for (int i = 0; i < 800; i++) begin
      ss  = ($urandom_range(0, 15) == 0);
      clr = ($urandom_range(0, 79) == 0);
      lp  = ($urandom_range(0, 7) == 0);
      drive_cycle(ss, clr, lp);
      checks++;
      if (minutes !== 6'(exp_total() / 60) || seconds !== 6'(exp_total() % 60)) begin
        errors++; $display("[TB] FAIL rand_time_c%0d: got %0d:%0d expected %0d:%0d", i, minutes, seconds, exp_total() / 60, exp_total() % 60);
      end
      checks++;
      if (running !== m_run || lap_held !== m_lap_held) begin
        errors++; $display("[TB] FAIL rand_flags_c%0d: got run=%0d held=%0d expected %0d %0d", i, running, lap_held, m_run, m_lap_held);
      end
      checks++;
      if (second_tick !== 1'(exp_tick()) || overflow !== 1'(exp_overflow())) begin
        errors++; $display("[TB] FAIL rand_tick_ovf_c%0d: got tick=%0d ovf=%0d expected %0d %0d", i, second_tick, overflow, exp_tick(), exp_overflow());
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    model_reset();
    test_reset();
    test_run();
    test_pause();
    test_overflow();
    test_lap();
    test_simultaneous();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/stopwatch_controller.md
Name: stopwatch_controller

Overview:
Timekeeping and control core for the stopwatch. Converts the system clock into a 1 Hz count and holds minutes/seconds (00:00–59:59). Sequences run, pause and clear from user pulses, and provides a lap-hold freeze. Its minutes/seconds outputs drive the seven-segment display driver directly.

Parameters:
TICK_DIV, 100_000_000, clock cycles per counted second (≥2); benches use 4
PRESC_W, $clog2(TICK_DIV), prescaler width (derived, not overridden)

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high reset
start_stop_pulse  in  1  one-cycle pulse, synchronised/debounced upstream; toggles run/pause
clear_pulse  in  1  one-cycle pulse; stop and zero everything
lap_pulse  in  1  one-cycle pulse; toggle lap hold
minutes  out  6  displayed minutes 0–59
seconds  out  6  displayed seconds 0–59
running  out  1  high in RUNNING state
lap_held  out  1  high while display is frozen
overflow  out  1  sticky; set on wrap 59:59→00:00
second_tick  out  1  one-cycle pulse on each live-count increment

Behaviour:
- Reset (async): state IDLE; prescaler, live min/sec, lap min/sec = 0; all outputs 0.
- States: IDLE (stopped, zero), RUNNING, PAUSED.
  - IDLE: start_stop → RUNNING. lap ignored.
  - RUNNING: start_stop → PAUSED. clear → IDLE.
  - PAUSED: start_stop → RUNNING. clear → IDLE.
- Priority within a cycle: clear > start_stop > lap.
- Prescaler:
  - Advances only in RUNNING; 0..TICK_DIV-1, then wraps to 0.
  - The cycle it equals TICK_DIV-1 in RUNNING is a tick: second_tick=1 that cycle (combinational from registers); live count increments at that edge.
  - Holds its value in PAUSED (resume keeps the partial second). Zeroed by clear.
  - First increment after start from IDLE: exactly TICK_DIV RUNNING cycles after the start pulse edge.
- Live count on tick:
  - sec<59 → sec+1.
  - sec=59 → sec=0, min+1.
  - 59:59 → 00:00 and overflow←1. Counting continues.
- Tick coincident with start_stop in RUNNING: increment happens, then PAUSED.
- Tick coincident with clear: clear wins; result 00:00.
- Lap:
  - In RUNNING with lap_held=0, lap_pulse captures the live min/sec (pre-increment value if tick coincides) and sets lap_held=1.
  - With lap_held=1, lap_pulse clears lap_held in RUNNING or PAUSED.
  - lap_pulse in PAUSED with lap_held=0 is ignored.
- Outputs:
  - minutes/seconds = lap_held ? lap regs : live regs (mux of registers, zero latency).
  - running = (state==RUNNING).
- clear: state IDLE; prescaler, live, lap regs, lap_held and overflow all cleared, effective next edge.
- reset asserted mid-run: all outputs go to 0 immediately, without a clock edge.

Decomposition:
- stopwatch_pkg:
  - state encodings IDLE=2'd0, RUNNING=2'd1, PAUSED=2'd2 (2'd3 unreachable, recovers to IDLE)
  - constants SEC_MAX=6'd59, MIN_MAX=6'd59
- Sub-module tick_prescaler (params TICK_DIV; ports clock, reset, enable, clear, tick): holds the prescaler counter and terminal-count detect. The FSM, mod-60 counters and lap logic stay in the top.

Test Plan:
1. TICK_DIV=4; reset, then start_stop → running=1 next cycle; seconds=1 after 4 cycles; minutes=1, seconds=0 after 240 cycles; second_tick high once per 4 cycles.
2. Run 10 cycles (00:02, prescaler=2), start_stop, idle 100 cycles → stays 00:02, running=0; start_stop again → 00:03 after 2 more cycles.
3. Run 3599 ticks to 59:59, one more tick → 00:00 with overflow=1 and counting continuing; clear_pulse → overflow=0, state IDLE.
4. Lap at 00:05 → outputs frozen at 00:05, lap_held=1, for 12 cycles; lap again → outputs 00:08, lap_held=0. Lap coincident with tick at 00:05 → captures 00:05.
5. Simultaneous events: clear+start_stop in RUNNING → IDLE, 00:00, running=0. start_stop coincident with tick at 00:03 → 00:04 and PAUSED. lap in PAUSED with lap_held=0 → no change.
6. Assert reset asynchronously mid-run at 12:34 with lap_held=1 → minutes=seconds=0, running=lap_held=overflow=0 before the next clock edge; release → IDLE.
